// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment scan bus plus decoded-result outputs.
// The panel/stimulus side uses master; the decoder uses slave.
interface seg7_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic                err_clr;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   valid_mask;
  logic                capture;
  logic                frame_done;
  logic                err_sticky;

  modport master (
    output seg_in,
    output dig_sel,
    output err_clr,
    input  value,
    input  valid_mask,
    input  capture,
    input  frame_done,
    input  err_sticky
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    input  err_clr,
    output value,
    output valid_mask,
    output capture,
    output frame_done,
    output err_sticky
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: dwell-qualified capture and glyph-to-hex decode.
// Optional macro SEG_ACTIVE_LOW_EN treats seg_in as active-low (0 = lit).
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int            CW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Returns {match, nibble}; match=0 for any pattern outside the hex glyph set.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h7B:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  function automatic logic is_one_hot(input logic [DIGITS-1:0] sel);
    return (sel != {DIGITS{1'b0}}) &&
           ((sel & (sel - DIGITS'(1))) == {DIGITS{1'b0}});
  endfunction

  logic [6:0]          seg_raw_s;
  logic [6:0]          seg_meta_r;
  logic [6:0]          s_seg_r;
  logic [DIGITS-1:0]   sel_meta_r;
  logic [DIGITS-1:0]   s_sel_r;
  logic [6:0]          prev_seg_r;
  logic [DIGITS-1:0]   prev_sel_r;
  logic [CW-1:0]       dwell_r;
  state_t              state_r;
  state_t              state_nxt_s;
  logic                changed_s;
  logic                one_hot_s;
  logic                capture_s;
  logic [4:0]          dec_s;
  logic                seen_full_s;
  logic [4*DIGITS-1:0] value_r;
  logic [DIGITS-1:0]   valid_r;
  logic [DIGITS-1:0]   seen_r;
  logic                capture_r;
  logic                frame_done_r;
  logic                err_r;

  // Segment polarity normalisation ahead of the synchronizer.
  always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
    seg_raw_s = ~bus.seg_in;
`else
    seg_raw_s = bus.seg_in;
`endif
  end

  // Two-flop synchronizers plus last-cycle copy used for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_r <= 7'h00;
      s_seg_r    <= 7'h00;
      sel_meta_r <= {DIGITS{1'b0}};
      s_sel_r    <= {DIGITS{1'b0}};
      prev_seg_r <= 7'h00;
      prev_sel_r <= {DIGITS{1'b0}};
    end else begin
      seg_meta_r <= seg_raw_s;
      s_seg_r    <= seg_meta_r;
      sel_meta_r <= bus.dig_sel;
      s_sel_r    <= sel_meta_r;
      prev_seg_r <= s_seg_r;
      prev_sel_r <= s_sel_r;
    end
  end

  always_comb begin
    changed_s   = (s_seg_r != prev_seg_r) || (s_sel_r != prev_sel_r);
    one_hot_s   = is_one_hot(s_sel_r);
    dec_s       = glyph_decode(s_seg_r);
    seen_full_s = (seen_r == {DIGITS{1'b1}});
  end

  // Dwell counter: restarts at 1 on any pair change, saturates at the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r <= {CW{1'b0}};
    end else if (changed_s) begin
      dwell_r <= CW'(1);
    end else if (dwell_r != DWELL_MAX) begin
      dwell_r <= dwell_r + CW'(1);
    end else begin
      dwell_r <= dwell_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; HOLD guarantees a single capture per stable dwell.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (one_hot_s) begin
          state_nxt_s = ST_DWELL;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DWELL: begin
        if (changed_s) begin
          if (one_hot_s) begin
            state_nxt_s = ST_DWELL;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else if (dwell_r == DWELL_MAX) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_DWELL;
        end
      end
      ST_HOLD: begin
        if (changed_s) begin
          if (one_hot_s) begin
            state_nxt_s = ST_DWELL;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT;
      end
    endcase
  end

  // Capture datapath: an unrecognised glyph keeps the old nibble but drops its valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture_r <= 1'b0;
      value_r   <= {(4*DIGITS){1'b0}};
      valid_r   <= {DIGITS{1'b0}};
    end else begin
      capture_r <= capture_s;
      for (int i = 0; i < DIGITS; i++) begin
        if (capture_s && s_sel_r[i]) begin
          if (dec_s[4]) begin
            value_r[4*i +: 4] <= dec_s[3:0];
            valid_r[i]        <= 1'b1;
          end else begin
            valid_r[i]        <= 1'b0;
          end
        end
      end
    end
  end

  // Seen-mask and frame pulse; the pulse lands one edge after the completing capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_r       <= {DIGITS{1'b0}};
      frame_done_r <= 1'b0;
    end else if (seen_full_s) begin
      seen_r       <= capture_s ? s_sel_r : {DIGITS{1'b0}};
      frame_done_r <= 1'b1;
    end else begin
      seen_r       <= capture_s ? (seen_r | s_sel_r) : seen_r;
      frame_done_r <= 1'b0;
    end
  end

  // Sticky error; a new bad glyph wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (capture_s && !dec_s[4]) begin
      err_r <= 1'b1;
    end else if (bus.err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.value      = value_r;
  assign bus.valid_mask = valid_r;
  assign bus.capture    = capture_r;
  assign bus.frame_done = frame_done_r;
  assign bus.err_sticky = err_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed table, reset sequences and
// randomized segment runs against a schedule-based reference model.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int MAXE   = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DIGITS-1:0]   sel;
    logic [6:0]          seg;
    int                  hold;
    int                  clr_at;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   valid;
    logic                err;
    int                  caps;
    int                  frames;
  } vec_t;

  vec_t tbl [14];

  int checks = 0;
  int errors = 0;
  int cur_edge = 0;
  int ent_caps;
  int ent_frames;

  logic [6:0] glyph [16];

  // Reference model state: captures are scheduled by segment arithmetic.
  int                  cap_dig [MAXE];
  logic [6:0]          cap_seg [MAXE];
  logic [4*DIGITS-1:0] m_value;
  logic [DIGITS-1:0]   m_valid;
  logic [DIGITS-1:0]   m_seen;
  logic                m_err;
  int                  frame_edge;

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == s) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cur_edge);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXE; i++) begin
      cap_dig[i] = -1;
      cap_seg[i] = 7'h00;
    end
    m_value    = '0;
    m_valid    = '0;
    m_seen     = '0;
    m_err      = 1'b0;
    frame_edge = -1;
  endtask

  task automatic drive(input logic [DIGITS-1:0] sel, input logic [6:0] seg, input logic clr);
    bus.dig_sel = sel;
`ifdef SEG_ACTIVE_LOW_EN
    bus.seg_in  = ~seg;
`else
    bus.seg_in  = seg;
`endif
    bus.err_clr = clr;
  endtask

  // One clock: drive, advance, update the model for this edge and compare.
  task automatic step(input logic [DIGITS-1:0] sel, input logic [6:0] seg, input logic clr);
    logic cap_exp;
    logic fd_exp;
    int   d;
    int   nib;
    drive(sel, seg, clr);
    @(posedge clk);
    #1;
    cur_edge++;
    nib    = 0;
    fd_exp = (cur_edge == frame_edge);
    if (fd_exp) m_seen = '0;
    cap_exp = (cap_dig[cur_edge] >= 0);
    if (cap_exp) begin
      d   = cap_dig[cur_edge];
      nib = dec(cap_seg[cur_edge]);
      if (nib >= 0) begin
        m_value[4*d +: 4] = 4'(nib);
        m_valid[d]        = 1'b1;
      end else begin
        m_valid[d]        = 1'b0;
      end
      m_seen[d] = 1'b1;
      if (m_seen == {DIGITS{1'b1}}) frame_edge = cur_edge + 1;
    end
    if (cap_exp && nib < 0) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (bus.capture === 1'b1) ent_caps++;
    if (bus.frame_done === 1'b1) ent_frames++;
    check("model_capture", 32'(bus.capture), 32'(cap_exp));
    check("model_frame_done", 32'(bus.frame_done), 32'(fd_exp));
    check("model_value", 32'(bus.value), 32'(m_value));
    check("model_valid_mask", 32'(bus.valid_mask), 32'(m_valid));
    check("model_err_sticky", 32'(bus.err_sticky), 32'(m_err));
  endtask

  // A (sel, seg) pair held n clocks captures iff select is one-hot and n >= STABLE+1,
  // landing STABLE+2 edges after the first edge that samples it.
  task automatic run_seg(input logic [DIGITS-1:0] sel, input logic [6:0] seg,
                         input int n, input int clr_at);
    int t0;
    t0 = cur_edge + 1;
    if ($countones(sel) == 1 && n >= STABLE + 1 && t0 + 2 + STABLE < MAXE) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel[i]) cap_dig[t0 + 2 + STABLE] = i;
      end
      cap_seg[t0 + 2 + STABLE] = seg;
    end
    for (int k = 0; k < n; k++) step(sel, seg, k == clr_at);
  endtask

  initial begin
    int                  cap_k;
    int                  ncap;
    logic [DIGITS-1:0]   sel;
    logic [6:0]          seg;
    logic [DIGITS+6:0]   last_pair;
    int                  n;

    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71};

    tbl[0]  = '{4'b0001, 7'h3F, 10, -1, 16'h0000, 4'b0001, 1'b0, 1, 0};
    tbl[1]  = '{4'b0001, 7'h06,  8, -1, 16'h0001, 4'b0001, 1'b0, 1, 0};
    tbl[2]  = '{4'b0010, 7'h5B,  8, -1, 16'h0021, 4'b0011, 1'b0, 1, 0};
    tbl[3]  = '{4'b0100, 7'h77,  8, -1, 16'h0A21, 4'b0111, 1'b0, 1, 0};
    tbl[4]  = '{4'b1000, 7'h71,  8, -1, 16'hFA21, 4'b1111, 1'b0, 1, 1};
    tbl[5]  = '{4'b0100, 7'h7F,  3, -1, 16'hFA21, 4'b1111, 1'b0, 0, 0};
    tbl[6]  = '{4'b0100, 7'h6F,  8, -1, 16'hF921, 4'b1111, 1'b0, 1, 0};
    tbl[7]  = '{4'b0100, 7'h01,  8, -1, 16'hF921, 4'b1011, 1'b1, 1, 0};
    tbl[8]  = '{4'b0000, 7'h3F,  8,  0, 16'hF921, 4'b1011, 1'b0, 0, 0};
    tbl[9]  = '{4'b0100, 7'h01,  8,  6, 16'hF921, 4'b1011, 1'b1, 1, 0};
    tbl[10] = '{4'b0011, 7'h06, 20, -1, 16'hF921, 4'b1011, 1'b1, 0, 0};
    tbl[11] = '{4'b0000, 7'h06, 20, -1, 16'hF921, 4'b1011, 1'b1, 0, 0};
    tbl[12] = '{4'b0001, 7'h4F,  4, -1, 16'hF921, 4'b1011, 1'b1, 0, 0};
    tbl[13] = '{4'b0001, 7'h66,  7, -1, 16'hF924, 4'b1011, 1'b1, 1, 0};

    model_reset();

    // Reset with arbitrary inputs, then a non-one-hot select across the latency window.
    drive(DIGITS'($urandom_range(0, (1 << DIGITS) - 1)), 7'($urandom_range(0, 127)), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", 32'(bus.value), 32'h0);
    check("rst_valid_mask", 32'(bus.valid_mask), 32'h0);
    check("rst_capture", 32'(bus.capture), 32'h0);
    check("rst_frame_done", 32'(bus.frame_done), 32'h0);
    check("rst_err_sticky", 32'(bus.err_sticky), 32'h0);
    rst_n = 1'b1;
    run_seg(4'b0011, 7'h06, 2 + STABLE + 4, -1);

    // Reset in the middle of a dwell: no capture, and the dwell restarts after release.
    drive(4'b0001, 7'h06, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("middwell_pre_capture", 32'(bus.capture), 32'h0);
    end
    rst_n = 1'b0;
    #1;
    check("middwell_rst_capture", 32'(bus.capture), 32'h0);
    check("middwell_rst_valid", 32'(bus.valid_mask), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap_k = -1;
    ncap  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.capture === 1'b1) begin
        if (cap_k < 0) cap_k = k;
        ncap++;
      end
    end
    check("middwell_capture_edge", 32'(cap_k), 32'(3 + STABLE));
    check("middwell_capture_count", 32'(ncap), 32'd1);
    check("middwell_value", 32'(bus.value), 32'h0001);
    check("middwell_valid", 32'(bus.valid_mask), 32'h1);

    rst_n = 1'b0;
    drive('0, 7'h00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Directed vector table.
    for (int v = 0; v < 14; v++) begin
      ent_caps   = 0;
      ent_frames = 0;
      run_seg(tbl[v].sel, tbl[v].seg, tbl[v].hold, tbl[v].clr_at);
      check($sformatf("tbl%0d_value", v), 32'(bus.value), 32'(tbl[v].value));
      check($sformatf("tbl%0d_valid", v), 32'(bus.valid_mask), 32'(tbl[v].valid));
      check($sformatf("tbl%0d_err", v), 32'(bus.err_sticky), 32'(tbl[v].err));
      check($sformatf("tbl%0d_captures", v), 32'(ent_caps), 32'(tbl[v].caps));
      check($sformatf("tbl%0d_frames", v), 32'(ent_frames), 32'(tbl[v].frames));
    end

    // Randomized segment runs, including hold lengths around the capture threshold.
    last_pair = {4'b0001, 7'h66};
    for (int r = 0; r < 160; r++) begin
      if ($urandom_range(0, 9) < 7) begin
        sel = '0;
        sel[$urandom_range(0, DIGITS - 1)] = 1'b1;
      end else begin
        sel = DIGITS'($urandom_range(0, (1 << DIGITS) - 1));
      end
      if ($urandom_range(0, 9) < 8) seg = glyph[$urandom_range(0, 15)];
      else seg = 7'($urandom_range(0, 127));
      if ({sel, seg} != last_pair) begin
        n = $urandom_range(1, STABLE + 6);
        run_seg(sel, seg, n, $urandom_range(0, 40));
        last_pair = {sel, seg};
      end
    end
    run_seg(4'b0011, 7'h00, STABLE + 4, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive end of the 7-segment display interface. Samples a multiplexed display bus: a shared 7-bit segment bus plus one-hot digit select. Qualifies each digit's pattern for stability, decodes the glyph back to a 4-bit hex nibble, and assembles a DIGITS-wide word. Used for display loopback checking and for capturing panel output in SimVGA test builds.

Parameters:
DIGITS, 4, number of multiplexed digits, range 1..8.
STABLE_CYCLES, 4, consecutive synchronized cycles a (sel, seg) pair must hold before capture, range 2..255.

Ports:
clk      in   1          system clock
rst_n    in   1          asynchronous active-low reset
seg_in   in   7          segment lines; bit0=a … bit6=g, 1=lit
dig_sel  in   DIGITS     digit select, one-hot; bit i selects digit i
err_clr  in   1          synchronous clear of err_sticky
value    out  4*DIGITS   decoded nibbles; digit i at [4i+3:4i]
valid_mask out DIGITS    bit i=1: digit i holds a valid decode
capture  out  1          1-cycle pulse on every capture
frame_done out 1         1-cycle pulse when every digit has been captured since the last pulse
err_sticky out 1         set by any unrecognised glyph

Behaviour:
- Reset, asynchronous: value=0, valid_mask=0, capture=0, frame_done=0, err_sticky=0. Sync flops, dwell counter, seen-mask and FSM are cleared. FSM enters WAIT.
- Input path: seg_in and dig_sel each pass through a 2-flop synchronizer. All logic uses the stage-2 values (s_seg, s_sel).
- Dwell counter:
  - Reset to 1 when (s_seg, s_sel) differs from the previous cycle's value.
  - Otherwise increments and saturates at STABLE_CYCLES.
- FSM:
  - WAIT: goes to DWELL when s_sel is exactly one-hot. A zero or multi-hot select stays in WAIT and is never captured.
  - DWELL: a change in s_sel or s_seg returns the FSM to WAIT if the new select is not one-hot; otherwise it restarts the dwell count. When the dwell count reaches STABLE_CYCLES, a capture occurs on that edge and the FSM goes to HOLD.
  - HOLD: stays until (s_seg, s_sel) changes, then re-evaluates as WAIT. Only one capture is allowed per dwell.
- Latency: a (sel, seg) pair held stable from edge 0 produces its capture on edge 2+STABLE_CYCLES. capture, value and valid_mask update on the same edge.
- Decode table (seg hex, gfedcba → nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 7B→E, 71→F
- On capture of digit i:
  - Match: value nibble i is updated and valid_mask[i] is set.
  - No match: value nibble i is unchanged, valid_mask[i] is cleared, and err_sticky is set.
  - In both cases, seen[i] is set.
- frame_done: pulses on the edge after the capture that makes seen all-ones. seen clears on that same edge. Re-capturing the same digit before all digits have been seen is allowed and keeps the latest result.
- err_sticky: cleared by err_clr. A set event and err_clr in the same cycle leaves it set.
- Reset mid-dwell: no capture occurs, and the dwell restarts from scratch after reset release.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined: seg_in is treated as active-low (0=lit) and inverted before the synchronizer. The decode table and everything downstream are unchanged.
- Undefined: seg_in is active-high as specified above.

Test Plan:
1. Assert rst_n=0 with arbitrary inputs, then release → all outputs 0, and no capture during the first 2+STABLE_CYCLES cycles with a non-one-hot select.
2. dig_sel=0001, seg_in=7'h3F held 10 cycles → exactly one capture pulse, on edge 6. Result: value[3:0]=0, valid_mask=0001.
3. Scan digit0=06, digit1=5B, digit2=77, digit3=71, each held 8 cycles → value=16'hFA21, valid_mask=1111. frame_done pulses once, one cycle after the 4th capture.
4. dig_sel=0100, seg=7'h7F held 3 cycles, then 7'h6F held 8 cycles → no capture of 8. Nibble 2 becomes 9.
5. dig_sel=0100, seg=7'h01 held 8 cycles → valid_mask[2]=0, nibble 2 unchanged, err_sticky=1. Pulsing err_clr clears err_sticky. A second invalid capture coinciding with err_clr leaves err_sticky=1.
6. dig_sel=0011 or 0000 held 20 cycles → no capture and outputs unchanged. With SEG_ACTIVE_LOW_EN defined, dig_sel=0001, seg=7'h40 → nibble 0=0.
